// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache write-back buffer.
// Line geometry is fixed here so the cache, buffer and memory agree on the line layout.
package dcache_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS) + 2;

    // Clears the byte/word offset so addresses compare at line granularity.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        line_t             words;
    } wb_entry_t;

    typedef enum logic [0:0] {
        IDLE,
        DRAIN
    } wb_state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & LINE_MASK;
    endfunction

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Bus bundle of the write-back buffer: enqueue from the cache, drain to memory,
// refill lookup and occupancy status. slave is the buffer side, master the cache/memory side.
interface dcache_wb_buffer_if
    import dcache_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              enq_valid;
    logic              enq_ready;
    logic [ADDR_W-1:0] enq_addr;
    line_t             enq_words;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    line_t             mem_words;
    logic              mem_ack;

    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    line_t             lookup_words;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output enq_valid, enq_addr, enq_words, mem_ack, lookup_addr,
        input  enq_ready, mem_we, mem_addr, mem_words, lookup_hit, lookup_words,
        input  count, empty, full
    );

    modport slave (
        input  enq_valid, enq_addr, enq_words, mem_ack, lookup_addr,
        output enq_ready, mem_we, mem_addr, mem_words, lookup_hit, lookup_words,
        output count, empty, full
    );

endinterface

// File: rtl/wb_lookup.sv
// DEPTH-way line-address compare over the buffered entries, returning the youngest match.
// Search starts just below the write pointer, so the newest copy of a duplicate address wins.
module wb_lookup
    import dcache_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       hit,
    output line_t                      words
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] line_addr;
    logic [PTR_W-1:0]  idx;

    assign line_addr = line_base(lookup_addr);

    always_comb begin
        hit   = 1'b0;
        words = '0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = wr_ptr - PTR_W'(i + 1);
            if (!hit && entries[idx].valid && (entries[idx].addr == line_addr)) begin
                hit   = 1'b1;
                words = entries[idx].words;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the data cache and data memory: circular FIFO of evicted lines
// drained in order. Define WB_FORWARD_EN to build the refill lookup/forwarding path.
module dcache_wb_buffer
    import dcache_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_wb_buffer_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    wb_state_t        state_q;
    wb_state_t        state_d;

    logic      full;
    logic      push;
    logic      pop;
    wb_entry_t head;

    assign full = (count_q == CNT_W'(DEPTH));
    // Acceptance looks only at registered occupancy: no enqueue into a slot freed this cycle.
    assign push = bus.enq_valid && !full;
    assign pop  = (state_q == DRAIN) && bus.mem_ack;
    assign head = entries_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // count_d already includes a same-cycle enqueue, so a fresh line starts draining at once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_d != '0) state_d = DRAIN;
            DRAIN:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                entries_q[wr_ptr_q] <= '{valid: 1'b1,
                                         addr:  line_base(bus.enq_addr),
                                         words: bus.enq_words};
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign bus.enq_ready = !full;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = full;
    assign bus.mem_we    = (state_q == DRAIN);
    assign bus.mem_addr  = ((state_q == DRAIN) && head.valid) ? head.addr  : '0;
    assign bus.mem_words = ((state_q == DRAIN) && head.valid) ? head.words : '0;

`ifdef WB_FORWARD_EN
    wb_lookup #(
        .DEPTH (DEPTH)
    ) u_lookup (
        .entries     (entries_q),
        .wr_ptr      (wr_ptr_q),
        .lookup_addr (bus.lookup_addr),
        .hit         (bus.lookup_hit),
        .words       (bus.lookup_words)
    );
`else
    // Without forwarding the cache waits for empty before refilling, so no lookup is needed.
    logic unused_lookup;
    assign unused_lookup    = ^bus.lookup_addr;
    assign bus.lookup_hit   = 1'b0;
    assign bus.lookup_words = '0;
`endif

endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Write-back buffer between the set-associative data cache and data memory. Accepts evicted dirty lines from the cache in one cycle, so the cache can start its refill at once, and drains them in order to data memory. Offers a lookup port so a refill of a line that is still buffered returns the newest buffered copy, not stale memory contents.

## Interface
- DEPTH, 2: number of buffered lines; power of two, 2 to 8.
- LINE_WORDS, 4: 32-bit words per line.
- ADDR_W, 32: address width.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- enq_valid  in  1  cache presents an evicted line.
- enq_ready  out  1  buffer can accept a line this cycle.
- enq_addr  in  ADDR_W  line base address; bits [$clog2(LINE_WORDS)+1:0] ignored and stored as 0.
- enq_words  in  LINE_WORDS x 32  line data, word 0 at the lowest address.
- mem_we  out  1  write request to data memory.
- mem_addr  out  ADDR_W  line address of the head entry.
- mem_words  out  LINE_WORDS x 32  head entry data.
- mem_ack  in  1  data memory accepted the write on this edge.
- lookup_addr  in  ADDR_W  refill address from the cache; compared at line granularity.
- lookup_hit  out  1  a buffered entry matches lookup_addr.
- lookup_words  out  LINE_WORDS x 32  data of the youngest matching entry; 0 when there is no hit.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Circular FIFO of DEPTH entries. Each entry holds {valid, line address, line words}. Write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Enqueue: the entry is written on a rising edge where enq_valid & enq_ready. enq_ready = !full, taken from registered state. There is no pass-through: a full buffer refuses enqueue even if a pop happens in the same cycle.
- Drain FSM:
  - IDLE: mem_we = 0. Moves to DRAIN when count != 0.
  - DRAIN: mem_we = 1; mem_addr and mem_words show the head entry and stay stable until mem_ack.
    - On mem_ack: pop the head.
    - Stay in DRAIN if at least one entry remains after the pop, counting any enqueue in the same cycle.
    - Otherwise go to IDLE.
- mem_ack outside DRAIN is ignored.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Duplicate addresses are allowed. There is no coalescing: duplicates drain in enqueue order, so the last write wins in memory.
- Lookup is combinational over all valid entries and reports the youngest match. An entry popped on an edge stops matching after that edge; it is in memory by then.
- An enqueue is not visible to lookup until the edge that writes it.

## Timing
- Reset values: count 0, empty 1, full 0, enq_ready 1, mem_we 0, mem_addr 0, mem_words 0, lookup_hit 0, lookup_words 0, FSM in IDLE, all entries invalid, pointers 0.
- Reset mid-operation clears everything asynchronously, including pending lines. Those lines are lost; the cache resets at the same time.
- Enqueue into an empty buffer at edge N: mem_we = 1 in the cycle after edge N.
- mem_ack tied high gives one line per cycle, back-to-back, with no idle cycle between entries.
- lookup path: combinational from lookup_addr and registered entries, with no clock latency.

## Configuration
- WB_FORWARD_EN defined:
  - the lookup comparators and the forwarding mux are built;
  - the cache may refill while the buffer is non-empty.
- WB_FORWARD_EN undefined:
  - lookup_hit and lookup_words are tied to 0 and no comparators are built;
  - the cache holds any refill until empty == 1, so memory is always coherent before a read.

## Structure
- Shared package dcache_pkg:
  - LINE_WORDS and word width constants;
  - line_t, the array of LINE_WORDS 32-bit words;
  - wb_entry_t struct {valid, addr, line_t words};
  - wb_state_t enum {IDLE, DRAIN}.
- One sub-module, wb_lookup: the DEPTH-way address compare plus youngest-match priority select. It is instantiated only under WB_FORWARD_EN.

## Test plan
- Reset, then enqueue addr 0x0000_1010 with words 0x11,0x22,0x33,0x44 and mem_ack tied 1:
  - mem_we = 1 on the next cycle with mem_addr 0x0000_1010 and those words;
  - empty = 1 one cycle later.
- Hold mem_ack = 0 and enqueue lines 0x100, then 0x200:
  - full = 1 and enq_ready = 0;
  - a third enq_valid is not accepted;
  - pulse mem_ack: mem_addr 0x100 is written first, then 0x200, and count steps 2, 1, 0.
- With the buffer full, enq_valid and mem_ack in the same cycle:
  - the enqueue is refused and the pop happens, so count goes from 2 to 1;
  - the next cycle the enqueue is accepted and count returns to 2.
- WB_FORWARD_EN, mem_ack = 0, enqueue 0x300 with data A, then 0x300 with data B:
  - lookup_addr 0x30C gives lookup_hit = 1 and lookup_words = B;
  - lookup_addr 0x400 gives hit 0 and words 0.
- Pointer wrap: DEPTH = 2, 6 enqueues with acks interleaved:
  - all 6 lines reach memory in order with no loss or duplication.
- Assert RST low while in DRAIN with count = 2:
  - mem_we drops immediately, count = 0, empty = 1;
  - the first enqueue after release is written correctly.
